// File: rtl/retire_obs_tracker.sv
// retire_obs_tracker: in-order tracker that builds one retirement observation per issued instruction.
// Optional OBS_MEM_MASK_EN: width/sign-accurate mem data in the retired record.
module retire_obs_tracker #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_instr_i,
  input  logic [31:0] issue_rs1_data_i,
  input  logic [31:0] issue_rs2_data_i,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_rvalid_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_data_i,
  output logic        retire_o,
  output logic [31:0] instr_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] reg_rs1_o,
  output logic [31:0] reg_rs2_o,
  output logic [31:0] reg_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_w_data_o,
  output logic [31:0] mem_r_data_o,
  output logic        full_o,
  output logic        overflow_o,
  output logic        protocol_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] rs1_q   [DEPTH];
  logic [31:0] rs2_q   [DEPTH];
  logic [31:0] addr_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [31:0] rdata_q [DEPTH];
  logic [31:0] wbd_q   [DEPTH];
  logic [DEPTH-1:0] need_req_q, need_rsp_q, need_wb_q;
  logic [CW-1:0] head_q, tail_q, head_d, tail_d, count;
  logic [AW-1:0] head_idx, tail_idx, idx, req_idx, rsp_idx, wb_idx;
  logic req_hit, rsp_hit, wb_hit;
  logic ev_req, ev_rsp, ev_wb;
  logic full, empty, head_done, pop, push, drop, perr_d;
  logic is_ld, is_st;
  logic [31:0] h_instr, h_rdata, h_wdata;
  logic h_ld, h_st;
  logic overflow_q, perr_q, retire_q;
  logic [31:0] out_instr_q, out_rs1_q, out_rs2_q, out_rd_q, out_addr_q, out_wdata_q, out_rdata_q;

  function automatic logic writes_rd(input logic [31:0] ins);
    return ins[6:0] != OP_STORE && ins[6:0] != OP_BRANCH && ins[11:7] != 5'd0;
  endfunction

`ifdef OBS_MEM_MASK_EN
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] d);
    logic [31:0] s;
    s = d >> {lane, 3'b000};
    return f3[1:0] == 2'b00 ? {{24{s[7] & ~f3[2]}}, s[7:0]} :
           f3[1:0] == 2'b01 ? {{16{s[15] & ~f3[2]}}, s[15:0]} : d;
  endfunction

  function automatic logic [31:0] store_mask(input logic [1:0] f3, input logic [31:0] d);
    return f3 == 2'b00 ? {24'd0, d[7:0]} : f3 == 2'b01 ? {16'd0, d[15:0]} : d;
  endfunction
`endif

  assign head_idx  = head_q[AW-1:0];
  assign tail_idx  = tail_q[AW-1:0];
  assign count     = tail_q - head_q;
  assign empty     = head_q == tail_q;
  assign full      = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
  assign head_done = !empty && !need_req_q[head_idx] && !need_rsp_q[head_idx] && !need_wb_q[head_idx];
  assign pop       = head_done && !flush_i;
  assign push      = issue_valid_i && !flush_i && (!full || pop);
  assign drop      = issue_valid_i && !flush_i && full && !pop;
  assign head_d    = flush_i ? '0 : head_q + CW'(pop);
  assign tail_d    = flush_i ? '0 : tail_q + CW'(push);
  assign ev_req    = lsu_req_i && !flush_i;
  assign ev_rsp    = lsu_rvalid_i && !flush_i;
  assign ev_wb     = wb_valid_i && !flush_i;
  assign perr_d    = (ev_req && !req_hit) || (ev_rsp && !rsp_hit) || (ev_wb && !wb_hit);
  assign is_ld     = issue_instr_i[6:0] == OP_LOAD;
  assign is_st     = issue_instr_i[6:0] == OP_STORE;

  // Scan youngest to oldest so the last hit left standing is the oldest match.
  always_comb begin
    req_hit = 1'b0;
    rsp_hit = 1'b0;
    wb_hit  = 1'b0;
    req_idx = '0;
    rsp_idx = '0;
    wb_idx  = '0;
    idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = head_idx + AW'(i);
      if (CW'(i) < count) begin
        if (need_req_q[idx]) begin
          req_hit = 1'b1;
          req_idx = idx;
        end
        if (need_rsp_q[idx] && !need_req_q[idx]) begin
          rsp_hit = 1'b1;
          rsp_idx = idx;
        end
        if (need_wb_q[idx]) begin
          wb_hit = 1'b1;
          wb_idx = idx;
        end
      end
    end
  end

  // Push is written last so it wins when it reuses the slot being popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      need_req_q <= '0;
      need_rsp_q <= '0;
      need_wb_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
        wbd_q[i]   <= '0;
      end
    end else begin
      if (ev_req && req_hit) begin
        need_req_q[req_idx] <= 1'b0;
        addr_q[req_idx]     <= lsu_addr_i;
        wdata_q[req_idx]    <= lsu_wdata_i;
      end
      if (ev_rsp && rsp_hit) begin
        need_rsp_q[rsp_idx] <= 1'b0;
        if (instr_q[rsp_idx][6:0] == OP_LOAD) rdata_q[rsp_idx] <= lsu_rdata_i;
      end
      if (ev_wb && wb_hit) begin
        need_wb_q[wb_idx] <= 1'b0;
        wbd_q[wb_idx]     <= wb_data_i;
      end
      if (push) begin
        instr_q[tail_idx]    <= issue_instr_i;
        rs1_q[tail_idx]      <= issue_rs1_data_i;
        rs2_q[tail_idx]      <= issue_rs2_data_i;
        need_req_q[tail_idx] <= is_ld || is_st;
        need_rsp_q[tail_idx] <= is_ld || is_st;
        need_wb_q[tail_idx]  <= writes_rd(issue_instr_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_q | drop;
      perr_q     <= perr_q | perr_d;
    end
  end

  assign h_instr = instr_q[head_idx];
  assign h_ld    = h_instr[6:0] == OP_LOAD;
  assign h_st    = h_instr[6:0] == OP_STORE;
`ifdef OBS_MEM_MASK_EN
  assign h_rdata = load_ext(h_instr[14:12], addr_q[head_idx][1:0], rdata_q[head_idx]);
  assign h_wdata = store_mask(h_instr[13:12], wdata_q[head_idx]);
`else
  assign h_rdata = rdata_q[head_idx];
  assign h_wdata = wdata_q[head_idx];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_q    <= 1'b0;
      out_instr_q <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_rdata_q <= '0;
    end else begin
      retire_q <= pop;
      if (pop) begin
        out_instr_q <= h_instr;
        out_rs1_q   <= rs1_q[head_idx];
        out_rs2_q   <= rs2_q[head_idx];
        out_rd_q    <= writes_rd(h_instr) ? wbd_q[head_idx] : '0;
        out_addr_q  <= (h_ld || h_st) ? addr_q[head_idx] : '0;
        out_wdata_q <= h_st ? h_wdata : '0;
        out_rdata_q <= h_ld ? h_rdata : '0;
      end
    end
  end

  assign retire_o       = retire_q;
  assign instr_o        = out_instr_q;
  assign rd_o           = out_instr_q[11:7];
  assign rs1_o          = out_instr_q[19:15];
  assign rs2_o          = out_instr_q[24:20];
  assign reg_rs1_o      = out_rs1_q;
  assign reg_rs2_o      = out_rs2_q;
  assign reg_rd_o       = out_rd_q;
  assign mem_addr_o     = out_addr_q;
  assign mem_w_data_o   = out_wdata_q;
  assign mem_r_data_o   = out_rdata_q;
  assign full_o         = full;
  assign overflow_o     = overflow_q;
  assign protocol_err_o = perr_q;
endmodule
